multi_voice_phase_engine: RTL
=============================

# multi_voice_phase_engine

Parametrised, time-multiplexed phase accumulator for the synth voice bank. It keeps one PHASE_W-bit phase per voice in an internal array and updates every voice once per audio sample, using a single shared adder. Per-voice increments and octave shifts are runtime-writable. Updated phases stream out one voice per cycle to the waveform lookup and mixer stage downstream.

## Interface
- NUM_VOICES, 24, number of voices (2..64)
- PHASE_W, 32, phase accumulator width
- INC_W, 24, stored increment width (INC_W <= PHASE_W)
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- sample_tick_in  input  1  one-cycle pulse at the audio sample rate; starts a sweep
- gate_in  input  NUM_VOICES  per-voice note-on level
- inc_wr_en_in  input  1  increment table write strobe
- inc_wr_addr_in  input  $clog2(NUM_VOICES)  voice index to write
- inc_wr_data_in  input  INC_W  base phase increment
- inc_wr_shift_in  input  2  octave shift, 0..3 (x1, x2, x4, x8)
- phase_out  output  PHASE_W  updated phase of voice_idx_out
- voice_idx_out  output  $clog2(NUM_VOICES)  voice index of phase_out
- phase_valid_out  output  1  phase_out and voice_idx_out are valid this cycle
- wrap_out  output  1  this voice's phase wrapped past 2^PHASE_W on this update
- sweep_done_out  output  1  high together with the last voice's valid cycle
- overrun_out  output  1  sticky: a tick arrived while a sweep was in progress

## Operation
- Storage: per voice, the phase (PHASE_W bits), increment (INC_W bits), shift (2 bits) and gate_prev (1 bit).
- FSM states:
  - IDLE: on sample_tick_in, go to SWEEP with cnt=0.
  - SWEEP: process voice cnt and increment cnt; after processing voice NUM_VOICES-1, return to IDLE.
- Effective increment = zero-extend(inc) << shift, truncated to PHASE_W.
- Per-voice update, using gate_in[k] as sampled at voice k's processing edge:
  - gate=0: phase := 0, wrap=0.
  - gate=1, gate_prev=0 (note-on): phase := 0, wrap=0. This is a hard sync.
  - gate=1, gate_prev=1: phase := (phase + eff_inc) mod 2^PHASE_W; wrap = carry out.
  - After the update, gate_prev[k] := gate_in[k]. Gate changes between sweeps are seen only at the voice's own processing slot.
- Increment writes are accepted in any state.
  - An out-of-range address is ignored.
  - A write that targets the voice being processed on the same edge does not affect that update: the old value is used and the new value applies from the next sweep.
- A tick sampled while in SWEEP is dropped and sets overrun_out. The sweep in progress continues unaffected.
- Reset: every phase, increment, shift and gate_prev is cleared, the FSM goes to IDLE and any sweep in progress is aborted.

## Timing
- Edge numbering: E0 is the edge where the tick is sampled in IDLE; voice k is processed at edge E(k+1).
- Outputs are registered.
  - Voice k's result is visible in the cycle after E(k+1), which is 2 edges after the tick for voice 0.
  - phase_valid_out is high for exactly NUM_VOICES consecutive cycles, with voice_idx_out running 0..NUM_VOICES-1.
  - sweep_done_out is high only in the last of those cycles.
- Ticks sampled at E1..E(NUM_VOICES) count as overrun. A tick at E(NUM_VOICES+1) or later is accepted, so the minimum tick period is NUM_VOICES+1 cycles.
- When phase_valid_out=0: phase_out, voice_idx_out, wrap_out and sweep_done_out are all 0.
- Reset value of every output is 0, overrun_out included.
- A reset asserted at any edge takes effect at that edge. From the following cycle all outputs are 0 and no valid is issued until a new tick arrives.

## Test plan
- NUM_VOICES=4. Write voice 0 inc=11237, shift=0. Hold gate_in=4'b0001 and send 3 ticks.
  - Voice 0 reports phase 0, then 11237, then 22474.
  - Voices 1-3 report 0.
  - Each sweep shows 4 valid cycles, with sweep_done_out on idx 3.
- Voice 1 inc=11237, shift=1, gate held high, 3 ticks -> 0, 22474, 44948. Repeat with shift=3 -> 0, 89896, 179792.
- PHASE_W=32, INC_W=32, voice 2 inc=0x8000_0000, gate held high, 4 ticks:
  - Phases 0, 0x8000_0000, 0, 0x8000_0000.
  - wrap_out=1 only on the third update.
- Voice 0 running at phase 22474:
  - Drop its gate for one sweep -> phase 0.
  - Re-raise the gate -> next sweep reports 0, the one after reports 11237.
- Tick at E0, second tick at E2:
  - overrun_out rises and stays high.
  - The sweep completes normally with 4 valid cycles.
  - A tick at E5 is accepted.
- Two corner cases:
  - A write to voice 2 on voice 2's processing edge: the old increment is used this sweep and the new one on the next sweep.
  - rst_in asserted at E2: outputs are 0 from the next cycle, and a subsequent tick restarts every voice from phase 0.

Source files
------------

// File: rtl/multi_voice_phase_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_voice_phase_engine_if
//  Description : Control, increment-write and phase-stream bundle for the
//                time-multiplexed voice phase engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_voice_phase_engine_if #(
    parameter int NUM_VOICES = 24,
    parameter int PHASE_W    = 32,
    parameter int INC_W      = 24
);
    localparam int c_idx_w = $clog2(NUM_VOICES);

    logic                  sample_tick_in;
    logic [NUM_VOICES-1:0] gate_in;
    logic                  inc_wr_en_in;
    logic [c_idx_w-1:0]    inc_wr_addr_in;
    logic [INC_W-1:0]      inc_wr_data_in;
    logic [1:0]            inc_wr_shift_in;

    logic [PHASE_W-1:0]    phase_out;
    logic [c_idx_w-1:0]    voice_idx_out;
    logic                  phase_valid_out;
    logic                  wrap_out;
    logic                  sweep_done_out;
    logic                  overrun_out;

    // Stimulus / upstream side
    modport master (
        output sample_tick_in, gate_in, inc_wr_en_in, inc_wr_addr_in,
               inc_wr_data_in, inc_wr_shift_in,
        input  phase_out, voice_idx_out, phase_valid_out, wrap_out,
               sweep_done_out, overrun_out
    );

    // Engine side
    modport slave (
        input  sample_tick_in, gate_in, inc_wr_en_in, inc_wr_addr_in,
               inc_wr_data_in, inc_wr_shift_in,
        output phase_out, voice_idx_out, phase_valid_out, wrap_out,
               sweep_done_out, overrun_out
    );
endinterface
`default_nettype wire

// File: rtl/multi_voice_phase_engine.sv
`default_nettype none
// ============================================================================
//  Module      : multi_voice_phase_engine
//  Description : One phase accumulator per voice, all updated once per audio
//                sample through a single shared adder; results stream out one
//                voice per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_voice_phase_engine #(
    parameter int NUM_VOICES = 24,
    parameter int PHASE_W    = 32,
    parameter int INC_W      = 24
) (
    input  wire                          clk_in,
    input  wire                          rst_in,
    multi_voice_phase_engine_if.slave    bus
);
    localparam int                 c_idx_w    = $clog2(NUM_VOICES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_VOICES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_idx_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  w_cnt_nxt;
    logic                w_proc;
    logic                w_last;
    logic                w_overrun_set;

    // Per-voice storage
    logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
    logic [INC_W-1:0]      r_inc   [NUM_VOICES];
    logic [1:0]            r_shift [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate_prev;

    // Shared datapath for the voice currently in its slot
    logic                  w_gate;
    logic                  w_run;
    logic [PHASE_W-1:0]    w_inc_ext;
    logic [PHASE_W-1:0]    w_eff_inc;
    logic [PHASE_W:0]      w_sum;
    logic [PHASE_W-1:0]    w_phase_nxt;
    logic                  w_wrap_nxt;

    // Registered outputs
    logic [PHASE_W-1:0]    r_phase_out;
    logic [c_idx_w-1:0]    r_idx_out;
    logic                  r_valid_out;
    logic                  r_wrap_out;
    logic                  r_done_out;
    logic                  r_overrun_out;

    // Sweep sequencer state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sweep sequencer next state: one voice per cycle while sweeping
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_proc        = 1'b0;
        w_last        = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sample_tick_in) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                w_proc        = 1'b1;
                w_overrun_set = bus.sample_tick_in;
                w_cnt_nxt     = r_cnt + c_idx_w'(1);
                if (r_cnt == c_last_idx) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Shared adder: shifted increment added only while the note is held;
    // a fresh note-on (or gate low) forces the phase to zero
    always_comb begin
        w_gate      = bus.gate_in[r_cnt];
        w_run       = w_gate & r_gate_prev[r_cnt];
        w_inc_ext   = PHASE_W'(r_inc[r_cnt]);
        w_eff_inc   = w_inc_ext << r_shift[r_cnt];
        w_sum       = {1'b0, r_phase[r_cnt]} + {1'b0, w_eff_inc};
        w_phase_nxt = w_run ? w_sum[PHASE_W-1:0] : '0;
        w_wrap_nxt  = w_run & w_sum[PHASE_W];
    end

    // Voice tables; a same-edge write to the active voice lands after the
    // update has already read the old increment
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_inc[i]   <= '0;
                r_shift[i] <= '0;
            end
            r_gate_prev <= '0;
        end else begin
            if (bus.inc_wr_en_in && (32'(bus.inc_wr_addr_in) < NUM_VOICES)) begin
                r_inc[bus.inc_wr_addr_in]   <= bus.inc_wr_data_in;
                r_shift[bus.inc_wr_addr_in] <= bus.inc_wr_shift_in;
            end
            if (w_proc) begin
                r_phase[r_cnt]     <= w_phase_nxt;
                r_gate_prev[r_cnt] <= w_gate;
            end
        end
    end

    // Output stage: zeroed whenever no voice was processed on this edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_phase_out   <= '0;
            r_idx_out     <= '0;
            r_valid_out   <= 1'b0;
            r_wrap_out    <= 1'b0;
            r_done_out    <= 1'b0;
            r_overrun_out <= 1'b0;
        end else begin
            r_phase_out   <= w_proc ? w_phase_nxt : '0;
            r_idx_out     <= w_proc ? r_cnt : '0;
            r_valid_out   <= w_proc;
            r_wrap_out    <= w_proc & w_wrap_nxt;
            r_done_out    <= w_last;
            r_overrun_out <= r_overrun_out | w_overrun_set;
        end
    end

    assign bus.phase_out       = r_phase_out;
    assign bus.voice_idx_out   = r_idx_out;
    assign bus.phase_valid_out = r_valid_out;
    assign bus.wrap_out        = r_wrap_out;
    assign bus.sweep_done_out  = r_done_out;
    assign bus.overrun_out     = r_overrun_out;

endmodule
`default_nettype wire
